vx_commit_arbiter: RTL and testbench
====================================

VX_COMMIT_ARBITER -- requirements
Module: VX_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, which sets the thread lanes per request.
REQ-002 SHALL have parameter NW_BITS, default 2, which sets the warp id width.
REQ-003 SHALL have parameter NR_BITS, default 5, which sets the destination register id width.
REQ-004 SHALL have parameter NUM_REQS, default 6, which sets the number of functional-unit commit ports; the fixed index order is 0=ALU, 1=LSU, 2=CSR, 3=MUL, 4=FPU, 5=GPU.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low; 0 asserts reset.
REQ-007 cmt_valid_in  in  NUM_REQS  per-port commit request valid.
REQ-008 cmt_ready_out  out  NUM_REQS  per-port accept; the request transfers when valid and ready are both 1.
REQ-009 cmt_wid_in  in  NUM_REQS*NW_BITS  warp id per port.
REQ-010 cmt_tmask_in  in  NUM_REQS*NUM_THREADS  thread mask per port.
REQ-011 cmt_PC_in  in  NUM_REQS*32  instruction PC per port.
REQ-012 cmt_rd_in  in  NUM_REQS*NR_BITS  destination register per port.
REQ-013 cmt_wb_in  in  NUM_REQS  1 = writes a GPR; 0 = retire only.
REQ-014 cmt_eop_in  in  NUM_REQS  last packet of the instruction.
REQ-015 cmt_data_in  in  NUM_REQS*NUM_THREADS*32  result data per port.
REQ-016 wb_valid  out  1  writeback request valid.
REQ-017 wb_ready  in  1  GPR write port accept.
REQ-018 wb_wid / wb_tmask / wb_PC / wb_rd / wb_eop / wb_data  out  NW_BITS / NUM_THREADS / 32 / NR_BITS / 1 / NUM_THREADS*32  registered writeback payload.
REQ-019 retire_valid  out  1  one-cycle pulse marking an instruction retirement.
REQ-020 retire_count  out  $clog2(NUM_THREADS)+1  number of active threads in the retired instruction.

Function
REQ-021 can_accept SHALL equal (!wb_valid || wb_ready).
REQ-022 Arbitration SHALL be round-robin: the search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQS; the first valid port found is granted.
REQ-023 A grant SHALL issue only when can_accept=1; at most one port is granted per cycle.
REQ-024 cmt_ready_out[i] SHALL be 1 only for the granted port and SHALL be combinational, within the same cycle.
REQ-025 On a grant of port g, rr_ptr SHALL become (g+1) mod NUM_REQS on the next edge; with no grant, rr_ptr SHALL hold.
REQ-026 A granted request with wb=1 SHALL load the output register on the next edge and set wb_valid=1, giving 1-cycle latency.
REQ-027 A granted request with wb=0 SHALL NOT load the output register; wb_valid SHALL clear if the held entry drained in the same cycle.
REQ-028 When wb_valid && wb_ready and there is no new wb=1 grant, wb_valid SHALL clear on the next edge.
REQ-029 A simultaneous drain and new wb=1 grant SHALL replace the held entry with no bubble, sustaining full throughput.
REQ-030 While wb_valid && !wb_ready, the wb_* payload SHALL hold stable, no grants SHALL issue, and all cmt_ready_out SHALL be 0.
REQ-031 A grant with eop=1 SHALL pulse retire_valid=1 for exactly one cycle, on the edge after the grant, regardless of wb.
REQ-032 retire_count SHALL be the popcount of the granted tmask; it is 0 when the tmask is all zeros.
REQ-033 retire_count SHALL hold its last value when retire_valid=0.
REQ-034 A grant with eop=0 SHALL produce no retire pulse.
REQ-035 Ports with valid=0 SHALL never be granted, whatever rr_ptr points to.

Reset
REQ-036 When reset=0, asynchronously: wb_valid=0, retire_valid=0, retire_count=0, all wb_* payload=0, rr_ptr=0.
REQ-037 During reset, cmt_ready_out SHALL be all zeros.
REQ-038 On the first edge after reset deasserts, arbitration SHALL start at port 0.
REQ-039 Reset asserted mid-stall SHALL discard the held entry; no writeback or retire for it SHALL occur after reset.

Verification
REQ-040 All 6 ports valid, wb=1, wb_ready=1 -> grants in order 0,1,2,3,4,5,0 on consecutive cycles, with wb_valid continuously 1.
REQ-041 Port 3 wb=1, wb_ready=0 for 4 cycles -> wb payload stable, all cmt_ready_out=0 for those 4 cycles, port 3 drains on the 5th cycle.
REQ-042 Port 2 (CSR) wb=0, eop=1, tmask=4'b1011 -> wb_valid stays 0, retire_valid pulses 1 cycle later with retire_count=3.
REQ-043 rr_ptr=5 with only ports 1 and 5 valid -> port 5 granted, then port 1, then rr_ptr=2.
REQ-044 Reset asserted while wb_valid=1 and stalled -> wb_valid=0 immediately with no clock; port 0 is granted first after release.
REQ-045 eop=0 packet followed by an eop=1 packet from the same port (tmask 4'b1111) -> exactly one retire pulse, with count=4.

Source files
------------

// File: rtl/vx_commit_arbiter.sv
// rtl/vx_commit_arbiter.sv - round-robin commit arbiter feeding one registered GPR writeback port
// Also emits a one-cycle retire pulse with the active-thread count of each end-of-packet grant.

module vx_commit_arbiter #(
   parameter int NUM_THREADS = 4,
   parameter int NW_BITS     = 2,
   parameter int NR_BITS     = 5,
   parameter int NUM_REQS    = 6
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQS-1:0]                 cmt_valid_in,
   output logic [NUM_REQS-1:0]                 cmt_ready_out,
   input  logic [NUM_REQS*NW_BITS-1:0]         cmt_wid_in,
   input  logic [NUM_REQS*NUM_THREADS-1:0]     cmt_tmask_in,
   input  logic [NUM_REQS*32-1:0]              cmt_PC_in,
   input  logic [NUM_REQS*NR_BITS-1:0]         cmt_rd_in,
   input  logic [NUM_REQS-1:0]                 cmt_wb_in,
   input  logic [NUM_REQS-1:0]                 cmt_eop_in,
   input  logic [NUM_REQS*NUM_THREADS*32-1:0]  cmt_data_in,
   output logic                                wb_valid,
   input  logic                                wb_ready,
   output logic [NW_BITS-1:0]                  wb_wid,
   output logic [NUM_THREADS-1:0]              wb_tmask,
   output logic [31:0]                         wb_PC,
   output logic [NR_BITS-1:0]                  wb_rd,
   output logic                                wb_eop,
   output logic [NUM_THREADS*32-1:0]           wb_data,
   output logic                                retire_valid,
   output logic [$clog2(NUM_THREADS):0]        retire_count
);

   localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int CNT_W = $clog2(NUM_THREADS) + 1;
   localparam logic [PTR_W:0]   NREQ = (PTR_W+1)'(NUM_REQS);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQS - 1);

   logic [NW_BITS-1:0]          wid_a   [NUM_REQS];
   logic [NUM_THREADS-1:0]      tmask_a [NUM_REQS];
   logic [31:0]                 pc_a    [NUM_REQS];
   logic [NR_BITS-1:0]          rd_a    [NUM_REQS];
   logic [NUM_THREADS*32-1:0]   data_a  [NUM_REQS];

   for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
      assign wid_a[i]   = cmt_wid_in[i*NW_BITS +: NW_BITS];
      assign tmask_a[i] = cmt_tmask_in[i*NUM_THREADS +: NUM_THREADS];
      assign pc_a[i]    = cmt_PC_in[i*32 +: 32];
      assign rd_a[i]    = cmt_rd_in[i*NR_BITS +: NR_BITS];
      assign data_a[i]  = cmt_data_in[i*NUM_THREADS*32 +: NUM_THREADS*32];
   end

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W:0]   sum;
   logic             grant_any;
   logic             can_accept;
   logic             grant_valid;
   logic             grant_wb;
   logic             grant_eop;
   logic [CNT_W-1:0] grant_cnt;

   assign can_accept = !wb_valid || wb_ready;

   // Scan offsets high to low so the lowest offset from rr_ptr wins last.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      sum       = '0;
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         if (cmt_valid_in[sum[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = sum[PTR_W-1:0];
         end
      end
   end

   // Holding reset low keeps every port's ready deasserted.
   assign grant_valid = grant_any && can_accept && reset;
   assign grant_wb    = cmt_wb_in[grant_idx];
   assign grant_eop   = cmt_eop_in[grant_idx];

   always_comb begin
      cmt_ready_out = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         cmt_ready_out[i] = grant_valid && (grant_idx == PTR_W'(i));
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         grant_cnt = grant_cnt + {{(CNT_W-1){1'b0}}, tmask_a[grant_idx][t]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (grant_valid) begin
         rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid <= 1'b0;
         wb_wid   <= '0;
         wb_tmask <= '0;
         wb_PC    <= '0;
         wb_rd    <= '0;
         wb_eop   <= 1'b0;
         wb_data  <= '0;
      end else if (grant_valid && grant_wb) begin
         wb_valid <= 1'b1;
         wb_wid   <= wid_a[grant_idx];
         wb_tmask <= tmask_a[grant_idx];
         wb_PC    <= pc_a[grant_idx];
         wb_rd    <= rd_a[grant_idx];
         wb_eop   <= grant_eop;
         wb_data  <= data_a[grant_idx];
      end else if (wb_ready) begin
         wb_valid <= 1'b0;
      end
   end

   // Retire is independent of writeback: retire-only grants pulse it too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retire_valid <= 1'b0;
         retire_count <= '0;
      end else begin
         retire_valid <= grant_valid && grant_eop;
         if (grant_valid && grant_eop) begin
            retire_count <= grant_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb/tb_vx_commit_arbiter.sv - directed self-checking bench for vx_commit_arbiter

module tb_vx_commit_arbiter;

   localparam int NT = 4;
   localparam int NW = 2;
   localparam int NR = 5;
   localparam int NQ = 6;

   logic                 clk;
   logic                 reset;
   logic [NQ-1:0]        cmt_valid_in;
   logic [NQ-1:0]        cmt_ready_out;
   logic [NQ*NW-1:0]     cmt_wid_in;
   logic [NQ*NT-1:0]     cmt_tmask_in;
   logic [NQ*32-1:0]     cmt_PC_in;
   logic [NQ*NR-1:0]     cmt_rd_in;
   logic [NQ-1:0]        cmt_wb_in;
   logic [NQ-1:0]        cmt_eop_in;
   logic [NQ*NT*32-1:0]  cmt_data_in;
   logic                 wb_valid;
   logic                 wb_ready;
   logic [NW-1:0]        wb_wid;
   logic [NT-1:0]        wb_tmask;
   logic [31:0]          wb_PC;
   logic [NR-1:0]        wb_rd;
   logic                 wb_eop;
   logic [NT*32-1:0]     wb_data;
   logic                 retire_valid;
   logic [2:0]           retire_count;

   int tests_run;
   int tests_failed;

   vx_commit_arbiter #(
      .NUM_THREADS(NT), .NW_BITS(NW), .NR_BITS(NR), .NUM_REQS(NQ)
   ) dut (
      .clk(clk), .reset(reset),
      .cmt_valid_in(cmt_valid_in), .cmt_ready_out(cmt_ready_out),
      .cmt_wid_in(cmt_wid_in), .cmt_tmask_in(cmt_tmask_in),
      .cmt_PC_in(cmt_PC_in), .cmt_rd_in(cmt_rd_in),
      .cmt_wb_in(cmt_wb_in), .cmt_eop_in(cmt_eop_in),
      .cmt_data_in(cmt_data_in),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_PC(wb_PC),
      .wb_rd(wb_rd), .wb_eop(wb_eop), .wb_data(wb_data),
      .retire_valid(retire_valid), .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Port p carries rd=p+8, PC=0x1000+16p, wid=p%4, data lanes 0xDA7A0000+p.
   task automatic set_port(input int p, input logic v, input logic wb,
                           input logic eop, input logic [NT-1:0] tm);
      cmt_valid_in[p]            = v;
      cmt_wb_in[p]               = wb;
      cmt_eop_in[p]              = eop;
      cmt_tmask_in[p*NT +: NT]   = tm;
      cmt_rd_in[p*NR +: NR]      = NR'(p + 8);
      cmt_PC_in[p*32 +: 32]      = 32'h1000 + 32'(p * 16);
      cmt_wid_in[p*NW +: NW]     = NW'(p % 4);
      cmt_data_in[p*NT*32 +: NT*32] = {NT{32'hDA7A_0000 + 32'(p)}};
   endtask

   task automatic clear_ports();
      for (int p = 0; p < NQ; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      wb_ready = 1'b1;
      clear_ports();
      for (int p = 0; p < NQ; p++) set_port(p, 1'b1, 1'b1, 1'b1, 4'b1111);
      #2;
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      tests_run++;
      if (retire_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_retire_valid got %b exp 0", retire_valid); end
      tests_run++;
      if (retire_count !== 3'd0) begin tests_failed++; $display("FAIL reset_retire_count got %0d exp 0", retire_count); end
      tests_run++;
      if ({wb_rd, wb_PC, wb_tmask, wb_wid, wb_eop} !== '0 || wb_data !== '0) begin
         tests_failed++; $display("FAIL reset_payload rd=%h pc=%h exp all zero", wb_rd, wb_PC);
      end
      tests_run++;
      if (cmt_ready_out !== 6'b0) begin tests_failed++; $display("FAIL reset_ready got %b exp 000000", cmt_ready_out); end
      step();
      step();
      tests_run++;
      if (wb_valid !== 1'b0 || cmt_ready_out !== 6'b0) begin
         tests_failed++; $display("FAIL reset_held wb_valid=%b ready=%b exp 0/000000", wb_valid, cmt_ready_out);
      end
      for (int p = 0; p < NQ; p++) set_port(p, 1'b1, 1'b1, 1'b0, 4'b0001);
      reset = 1'b1;
   endtask

   task automatic test_round_robin();
      for (int k = 0; k < 7; k++) begin
         int e;
         e = k % NQ;
         #1;
         tests_run++;
         if (cmt_ready_out !== 6'(1 << e)) begin
            tests_failed++; $display("FAIL rr_ready[%0d] got %b exp port %0d", k, cmt_ready_out, e);
         end
         step();
         tests_run++;
         if (wb_valid !== 1'b1 || wb_rd !== NR'(e + 8)) begin
            tests_failed++; $display("FAIL rr_wb[%0d] valid=%b rd=%0d exp 1/%0d", k, wb_valid, wb_rd, e + 8);
         end
      end
      tests_run++;
      if (wb_data !== {NT{32'hDA7A_0000}} || wb_PC !== 32'h1000 || wb_wid !== 2'd0) begin
         tests_failed++; $display("FAIL rr_payload pc=%h wid=%0d data=%h exp port 0 payload", wb_PC, wb_wid, wb_data);
      end
      clear_ports();
      step();
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drain wb_valid got %b exp 0", wb_valid); end
   endtask

   task automatic test_stall();
      set_port(3, 1'b1, 1'b1, 1'b0, 4'b0110);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b001000) begin tests_failed++; $display("FAIL stall_grant3 got %b exp 001000", cmt_ready_out); end
      step();
      set_port(3, 1'b0, 1'b1, 1'b0, 4'b0110);
      set_port(0, 1'b1, 1'b1, 1'b0, 4'b0001);
      wb_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests_run++;
         if (cmt_ready_out !== 6'b0) begin tests_failed++; $display("FAIL stall_ready[%0d] got %b exp 000000", c, cmt_ready_out); end
         step();
         tests_run++;
         if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_PC !== 32'h1030 || wb_tmask !== 4'b0110) begin
            tests_failed++; $display("FAIL stall_hold[%0d] valid=%b rd=%0d pc=%h exp 1/11/1030", c, wb_valid, wb_rd, wb_PC);
         end
      end
      wb_ready = 1'b1;
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000001) begin tests_failed++; $display("FAIL stall_release got %b exp 000001", cmt_ready_out); end
      step();
      tests_run++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd8) begin
         tests_failed++; $display("FAIL stall_replace valid=%b rd=%0d exp 1/8", wb_valid, wb_rd);
      end
      clear_ports();
      step();
   endtask

   task automatic test_retire_no_wb();
      set_port(2, 1'b1, 1'b0, 1'b1, 4'b0000);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000100) begin tests_failed++; $display("FAIL csr_grant0 got %b exp 000100", cmt_ready_out); end
      step();
      tests_run++;
      if (retire_valid !== 1'b1 || retire_count !== 3'd0 || wb_valid !== 1'b0) begin
         tests_failed++; $display("FAIL zero_mask rv=%b cnt=%0d wbv=%b exp 1/0/0", retire_valid, retire_count, wb_valid);
      end
      set_port(2, 1'b1, 1'b0, 1'b1, 4'b1011);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000100) begin tests_failed++; $display("FAIL csr_grant1 got %b exp 000100", cmt_ready_out); end
      step();
      tests_run++;
      if (retire_valid !== 1'b1 || retire_count !== 3'd3 || wb_valid !== 1'b0) begin
         tests_failed++; $display("FAIL csr_retire rv=%b cnt=%0d wbv=%b exp 1/3/0", retire_valid, retire_count, wb_valid);
      end
      clear_ports();
      step();
      tests_run++;
      if (retire_valid !== 1'b0 || retire_count !== 3'd3) begin
         tests_failed++; $display("FAIL retire_hold rv=%b cnt=%0d exp 0/3", retire_valid, retire_count);
      end
   endtask

   task automatic test_rr_wrap();
      set_port(4, 1'b1, 1'b1, 1'b0, 4'b0001);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b010000) begin tests_failed++; $display("FAIL wrap_pre got %b exp 010000", cmt_ready_out); end
      step();
      clear_ports();
      set_port(1, 1'b1, 1'b1, 1'b0, 4'b0001);
      set_port(5, 1'b1, 1'b1, 1'b0, 4'b0001);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b100000) begin tests_failed++; $display("FAIL wrap_grant5 got %b exp 100000", cmt_ready_out); end
      step();
      tests_run++;
      if (wb_rd !== 5'd13) begin tests_failed++; $display("FAIL wrap_wb5 rd=%0d exp 13", wb_rd); end
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000010) begin tests_failed++; $display("FAIL wrap_grant1 got %b exp 000010", cmt_ready_out); end
      step();
      tests_run++;
      if (wb_rd !== 5'd9) begin tests_failed++; $display("FAIL wrap_wb1 rd=%0d exp 9", wb_rd); end
      set_port(2, 1'b1, 1'b1, 1'b0, 4'b0001);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000100) begin tests_failed++; $display("FAIL wrap_ptr2 got %b exp 000100", cmt_ready_out); end
      step();
      clear_ports();
      step();
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_drain wb_valid got %b exp 0", wb_valid); end
   endtask

   task automatic test_eop_sequence();
      set_port(3, 1'b1, 1'b1, 1'b0, 4'b1111);
      step();
      tests_run++;
      if (retire_valid !== 1'b0 || wb_rd !== 5'd11) begin
         tests_failed++; $display("FAIL eop0 rv=%b rd=%0d exp 0/11", retire_valid, wb_rd);
      end
      set_port(3, 1'b1, 1'b1, 1'b1, 4'b1111);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b001000) begin tests_failed++; $display("FAIL eop1_grant got %b exp 001000", cmt_ready_out); end
      step();
      tests_run++;
      if (retire_valid !== 1'b1 || retire_count !== 3'd4) begin
         tests_failed++; $display("FAIL eop1_retire rv=%b cnt=%0d exp 1/4", retire_valid, retire_count);
      end
      clear_ports();
      step();
      tests_run++;
      if (retire_valid !== 1'b0) begin tests_failed++; $display("FAIL eop_single_pulse rv=%b exp 0", retire_valid); end
   endtask

   task automatic test_reset_mid_stall();
      set_port(0, 1'b1, 1'b1, 1'b1, 4'b0011);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000001) begin tests_failed++; $display("FAIL mid_grant0 got %b exp 000001", cmt_ready_out); end
      step();
      tests_run++;
      if (wb_valid !== 1'b1 || retire_valid !== 1'b1 || retire_count !== 3'd2) begin
         tests_failed++; $display("FAIL mid_load wbv=%b rv=%b cnt=%0d exp 1/1/2", wb_valid, retire_valid, retire_count);
      end
      wb_ready = 1'b0;
      clear_ports();
      step();
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || retire_count !== 3'd0 || retire_valid !== 1'b0) begin
         tests_failed++; $display("FAIL mid_async wbv=%b rd=%0d cnt=%0d rv=%b exp all 0", wb_valid, wb_rd, retire_count, retire_valid);
      end
      set_port(0, 1'b1, 1'b1, 1'b0, 4'b0001);
      set_port(2, 1'b1, 1'b1, 1'b0, 4'b0001);
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b0) begin tests_failed++; $display("FAIL mid_ready_in_reset got %b exp 000000", cmt_ready_out); end
      step();
      reset    = 1'b1;
      wb_ready = 1'b1;
      #1;
      tests_run++;
      if (cmt_ready_out !== 6'b000001) begin tests_failed++; $display("FAIL mid_first_grant got %b exp 000001", cmt_ready_out); end
      step();
      tests_run++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd8 || retire_valid !== 1'b0) begin
         tests_failed++; $display("FAIL mid_after wbv=%b rd=%0d rv=%b exp 1/8/0", wb_valid, wb_rd, retire_valid);
      end
      clear_ports();
      step();
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_drain wb_valid got %b exp 0", wb_valid); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_round_robin();
      test_stall();
      test_retire_no_wb();
      test_rr_wrap();
      test_eop_sequence();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
